// File: rtl/cpu.sv
// cpu: minimal 65C02-compatible core, one registered bus cycle per clock.
// Latency: vector reads in the 2 cycles after RST release, first opcode fetch on the 3rd.
// Backpressure: RDY=0 freezes every register and bus output; only NMI edge capture keeps running.
module cpu (
    input  logic        clk,
    input  logic        RST,
    output logic [15:0] AD,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    output logic        WE,
    output logic        sync,
    input  logic        IRQ,
    input  logic        NMI,
    input  logic        RDY,
    input  logic        debug
);
    typedef enum logic [3:0] {
        VEC_LO, VEC_HI, T0, T1, T2, T3, T4, T5,
        I0, I1, I2, I3, I4, I5, I6
    } state_t;

    state_t      state, n_state;
    logic [7:0]  a, n_a, x, n_x, s, n_s, p, n_p, ir, n_ir, adl, n_adl;
    logic [15:0] pc, n_pc, ad_q, n_ad;
    logic [7:0]  do_q, n_do;
    logic        we_q, n_we, sync_q, n_sync;
    logic        nmi_prev, nmi_pend, nmi_sel, n_nmi_sel, nmi_clr, boundary;

    function automatic logic [7:0] set_nz(input logic [7:0] pin, input logic [7:0] v);
        logic [7:0] r;
        r    = pin;
        r[7] = v[7];
        r[1] = (v == 8'h00);
        return r;
    endfunction

    always_comb begin
        n_state   = state;
        n_a       = a;
        n_x       = x;
        n_s       = s;
        n_p       = p;
        n_ir      = ir;
        n_adl     = adl;
        n_pc      = pc;
        n_ad      = ad_q;
        n_we      = 1'b0;
        n_do      = 8'h00;
        n_sync    = 1'b0;
        n_nmi_sel = nmi_sel;
        nmi_clr   = 1'b0;
        boundary  = 1'b0;
        case (state)
            VEC_LO: begin
                n_pc    = {pc[15:8], DI};
                n_ad    = 16'hFFFD;
                n_state = VEC_HI;
            end
            VEC_HI: begin
                n_pc    = {DI, pc[7:0]};
                n_ad    = {DI, pc[7:0]};
                n_sync  = 1'b1;
                n_state = T0;
            end
            T0: begin
                n_ir    = DI;
                n_pc    = pc + 16'd1;
                n_ad    = pc + 16'd1;
                n_state = T1;
            end
            T1: begin
                case (ir)
                    8'hA9: begin
                        n_a      = DI;
                        n_p      = set_nz(p, DI);
                        n_pc     = pc + 16'd1;
                        boundary = 1'b1;
                    end
                    8'hA2: begin
                        n_x      = DI;
                        n_p      = set_nz(p, DI);
                        n_pc     = pc + 16'd1;
                        boundary = 1'b1;
                    end
                    8'h78: begin
                        n_p[2]   = 1'b1;
                        boundary = 1'b1;
                    end
                    8'h58: begin
                        n_p[2]   = 1'b0;
                        boundary = 1'b1;
                    end
                    8'h4C, 8'h8D: begin
                        n_adl   = DI;
                        n_pc    = pc + 16'd1;
                        n_ad    = pc + 16'd1;
                        n_state = T2;
                    end
                    8'h40: begin
                        n_ad    = {8'h01, s};
                        n_state = T2;
                    end
                    default: boundary = 1'b1;
                endcase
            end
            T2: begin
                if (ir == 8'h4C) begin
                    n_pc     = {DI, adl};
                    boundary = 1'b1;
                end else if (ir == 8'h8D) begin
                    n_pc    = pc + 16'd1;
                    n_ad    = {DI, adl};
                    n_we    = 1'b1;
                    n_do    = a;
                    n_state = T3;
                end else begin
                    n_s     = s + 8'd1;
                    n_ad    = {8'h01, s + 8'd1};
                    n_state = T3;
                end
            end
            T3: begin
                if (ir == 8'h40) begin
                    // B and bit 5 are not real storage; they always read back as 1
                    n_p     = DI | 8'h30;
                    n_s     = s + 8'd1;
                    n_ad    = {8'h01, s + 8'd1};
                    n_state = T4;
                end else begin
                    boundary = 1'b1;
                end
            end
            T4: begin
                n_pc    = {pc[15:8], DI};
                n_s     = s + 8'd1;
                n_ad    = {8'h01, s + 8'd1};
                n_state = T5;
            end
            T5: begin
                n_pc     = {DI, pc[7:0]};
                boundary = 1'b1;
            end
            I0: begin
                nmi_clr = 1'b1;
                n_state = I1;
            end
            I1: begin
                n_ad    = {8'h01, s};
                n_we    = 1'b1;
                n_do    = pc[15:8];
                n_state = I2;
            end
            I2: begin
                n_s     = s - 8'd1;
                n_ad    = {8'h01, s - 8'd1};
                n_we    = 1'b1;
                n_do    = pc[7:0];
                n_state = I3;
            end
            I3: begin
                n_s     = s - 8'd1;
                n_ad    = {8'h01, s - 8'd1};
                n_we    = 1'b1;
                n_do    = p & 8'hEF;
                n_state = I4;
            end
            I4: begin
                n_s     = s - 8'd1;
                n_p[2]  = 1'b1;
                n_ad    = nmi_sel ? 16'hFFFA : 16'hFFFE;
                n_state = I5;
            end
            I5: begin
                n_pc    = {pc[15:8], DI};
                n_ad    = ad_q | 16'h0001;
                n_state = I6;
            end
            I6: begin
                n_pc    = {DI, pc[7:0]};
                n_ad    = {DI, pc[7:0]};
                n_sync  = 1'b1;
                n_state = T0;
            end
            default: n_state = VEC_LO;
        endcase
        // Instruction boundary: either fetch the next opcode or start interrupt entry at the same PC
        if (boundary) begin
            n_ad = n_pc;
            if (nmi_pend || (!IRQ && !n_p[2])) begin
                n_state   = I0;
                n_nmi_sel = nmi_pend;
            end else begin
                n_state = T0;
                n_sync  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= VEC_LO;
            a        <= 8'h00;
            x        <= 8'h00;
            s        <= 8'hFD;
            p        <= 8'h34;
            ir       <= 8'h00;
            adl      <= 8'h00;
            pc       <= 16'h0000;
            ad_q     <= 16'hFFFC;
            we_q     <= 1'b0;
            do_q     <= 8'h00;
            sync_q   <= 1'b0;
            nmi_sel  <= 1'b0;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_prev <= NMI;
            nmi_pend <= (nmi_pend & ~(RDY & nmi_clr)) | (nmi_prev & ~NMI);
            if (RDY) begin
                state   <= n_state;
                a       <= n_a;
                x       <= n_x;
                s       <= n_s;
                p       <= n_p;
                ir      <= n_ir;
                adl     <= n_adl;
                pc      <= n_pc;
                ad_q    <= n_ad;
                we_q    <= n_we;
                do_q    <= n_do;
                sync_q  <= n_sync;
                nmi_sel <= n_nmi_sel;
            end
        end
    end

    assign AD   = ad_q;
    assign WE   = we_q;
    assign sync = sync_q;
    assign DO   = (debug && !we_q) ? ir : do_q;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: hand-traced bus sequences replayed against a flat 64K read memory.
module tb_cpu;
    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        WE;
    logic        sync;
    logic        IRQ;
    logic        NMI;
    logic        RDY;
    logic        debug;

    logic [7:0]  mem [0:65535];
    int          vectors = 0;
    int          miscompares = 0;

    cpu dut (
        .clk   (clk),
        .RST   (RST),
        .AD    (AD),
        .DI    (DI),
        .DO    (DO),
        .WE    (WE),
        .sync  (sync),
        .IRQ   (IRQ),
        .NMI   (NMI),
        .RDY   (RDY),
        .debug (debug)
    );

    assign DI = mem[AD];
    always #5 clk = ~clk;

    task automatic apply_reset(input logic irq_lvl, input logic dbg);
        RST   = 1'b0;
        IRQ   = irq_lvl;
        NMI   = 1'b1;
        RDY   = 1'b1;
        debug = dbg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (AD !== 16'hFFFC) begin
            miscompares++;
            $display("FAIL reset_ad: got %h want fffc", AD);
        end
        vectors++;
        if (WE !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_we: got %b want 0", WE);
        end
        vectors++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sync: got %b want 0", sync);
        end
        vectors++;
        if (DO !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_do: got %h want 00", DO);
        end
    endtask

    // Rows are {sync nibble, WE nibble, DO on writes (00 on reads), AD}
    task automatic test_boot_nop();
        logic [31:0] tr [0:7];
        logic [31:0] obs;
        tr = '{32'h0000_FFFC, 32'h0000_FFFD, 32'h1000_EAEA, 32'h0000_EAEB,
               32'h1000_EAEB, 32'h0000_EAEC, 32'h1000_EAEC, 32'h0000_EAED};
        apply_reset(1'b1, 1'b0);
        release_rst();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            obs = {3'b0, sync, 3'b0, WE, (WE ? DO : 8'h00), AD};
            vectors++;
            if (obs !== tr[i]) begin
                miscompares++;
                $display("FAIL boot[%0d]: got sync/we/do/ad %h want %h", i, obs, tr[i]);
            end
        end
    endtask

    task automatic test_program_irq();
        logic [31:0] tr [0:35];
        logic [31:0] obs;
        tr = '{32'h0000_FFFC, 32'h0000_FFFD, 32'h1000_0200, 32'h0000_0201,
               32'h1000_0202, 32'h0000_0203, 32'h0000_0204, 32'h0155_2000,
               32'h1000_0205, 32'h0000_0206, 32'h0000_0207, 32'h1000_1234,
               32'h0000_1235, 32'h1000_1236, 32'h0000_1237, 32'h0000_1237,
               32'h0000_1237, 32'h0112_01FD, 32'h0137_01FC, 32'h01A0_01FB,
               32'h0000_FFFE, 32'h0000_FFFF, 32'h1000_3000, 32'h0000_3001,
               32'h0000_01FA, 32'h0000_01FB, 32'h0000_01FC, 32'h0000_01FD,
               32'h1000_1237, 32'h0000_1238, 32'h0000_1238, 32'h0000_1238,
               32'h0112_01FD, 32'h0138_01FC, 32'h01A0_01FB, 32'h0000_FFFE};
        apply_reset(1'b0, 1'b0);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h30;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h55;
        mem[16'h0202] = 8'h8D; mem[16'h0203] = 8'h00; mem[16'h0204] = 8'h20;
        mem[16'h0205] = 8'h4C; mem[16'h0206] = 8'h34; mem[16'h0207] = 8'h12;
        mem[16'h1234] = 8'hA2; mem[16'h1235] = 8'h80; mem[16'h1236] = 8'h58;
        mem[16'h3000] = 8'h40;
        // Stack contents the interrupt entry is expected to leave behind
        mem[16'h01FB] = 8'hA0; mem[16'h01FC] = 8'h37; mem[16'h01FD] = 8'h12;
        release_rst();
        for (int i = 0; i < 36; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 20) IRQ = 1'b1;
            if (i == 28) IRQ = 1'b0;
            obs = {3'b0, sync, 3'b0, WE, (WE ? DO : 8'h00), AD};
            vectors++;
            if (obs !== tr[i]) begin
                miscompares++;
                $display("FAIL prog_irq[%0d]: got sync/we/do/ad %h want %h", i, obs, tr[i]);
            end
        end
        IRQ = 1'b1;
    endtask

    task automatic test_nmi();
        logic [31:0] tr [0:14];
        logic [31:0] obs;
        tr = '{32'h0000_FFFC, 32'h0000_FFFD, 32'h1000_0200, 32'h0000_0201,
               32'h0000_0202, 32'h0000_0400, 32'h0000_0400, 32'h0104_01FD,
               32'h0100_01FC, 32'h0124_01FB, 32'h0000_FFFA, 32'h0000_FFFB,
               32'h1000_5000, 32'h0000_5001, 32'h1000_5001};
        apply_reset(1'b1, 1'b0);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h50;
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h04;
        release_rst();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3) NMI = 1'b0;
            if (i == 4) NMI = 1'b1;
            obs = {3'b0, sync, 3'b0, WE, (WE ? DO : 8'h00), AD};
            vectors++;
            if (obs !== tr[i]) begin
                miscompares++;
                $display("FAIL nmi[%0d]: got sync/we/do/ad %h want %h", i, obs, tr[i]);
            end
        end
    endtask

    task automatic test_rdy_debug();
        apply_reset(1'b1, 1'b1);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h55;
        mem[16'h0202] = 8'h8D; mem[16'h0203] = 8'h00; mem[16'h0204] = 8'h20;
        release_rst();
        repeat (3) @(negedge clk);
        vectors++;
        if (DO !== 8'hA9) begin
            miscompares++;
            $display("FAIL debug_ir_lda: got DO %h want a9", DO);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (DO !== 8'h8D) begin
            miscompares++;
            $display("FAIL debug_ir_sta: got DO %h want 8d", DO);
        end
        repeat (2) @(negedge clk);
        RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({WE, DO, AD} !== {1'b1, 8'h55, 16'h2000}) begin
                miscompares++;
                $display("FAIL rdy_hold[%0d]: got we/do/ad %b/%h/%h want 1/55/2000", i, WE, DO, AD);
            end
        end
        RDY = 1'b1;
        @(negedge clk);
        vectors++;
        if ({sync, WE, AD} !== {1'b1, 1'b0, 16'h0205}) begin
            miscompares++;
            $display("FAIL rdy_resume: got sync/we/ad %b/%b/%h want 1/0/0205", sync, WE, AD);
        end
    endtask

    task automatic test_reset_mid_sta();
        apply_reset(1'b1, 1'b0);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h55;
        mem[16'h0202] = 8'h8D; mem[16'h0203] = 8'h00; mem[16'h0204] = 8'h20;
        release_rst();
        repeat (7) @(negedge clk);
        vectors++;
        if ({WE, AD} !== {1'b1, 16'h2000}) begin
            miscompares++;
            $display("FAIL sta_write: got we/ad %b/%h want 1/2000", WE, AD);
        end
        #2 RST = 1'b0;
        #1;
        vectors++;
        if ({WE, sync, AD} !== {1'b0, 1'b0, 16'hFFFC}) begin
            miscompares++;
            $display("FAIL rst_abort: got we/sync/ad %b/%b/%h want 0/0/fffc", WE, sync, AD);
        end
        @(negedge clk);
        RST = 1'b1;
    endtask

    initial begin
        RST   = 1'b1;
        IRQ   = 1'b1;
        NMI   = 1'b1;
        RDY   = 1'b1;
        debug = 1'b0;
        #1 RST = 1'b0;
        test_reset();
        test_boot_nop();
        test_program_irq();
        test_nmi();
        test_rdy_debug();
        test_reset_mid_sta();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
